bag_spawn_ctl: RTL and testbench
================================

// Module: bag_spawn_ctl
// PURPOSE
//  Scheduler for the falling-bag trajectory generators. Owns NBAGS bag slots and decides
//  when each is launched and with what arc scale. Tracks which slots are in flight and
//  collects per-slot landing results. Keeps score and misses, and ends the round after
//  MAX_MISSES drops. Sits between game top-level, LFSR random source and the bag engines.
// PARAMETERS
//  NBAGS       4       number of bag slots/trajectory engines (1..8)
//  TICK_DIV    800000  clk cycles per game tick (spawn timing granularity)
//  GAP_MIN     32      minimum ticks between launches
//  GAP_MASK    63      random jitter mask added to GAP_MIN (2^k-1)
//  MAX_MISSES  3       missed bags that end the round (1..7)
// PORTS
//  clk         in   1      system clock
//  rst_n       in   1      asynchronous, active-low reset
//  start       in   1      one-cycle pulse: start/restart round
//  random      in   10     free-running pseudo-random value
//  bag_done    in   NBAGS  per-slot 1-cycle pulse: bag finished (caught or hit floor)
//  bag_caught  in   NBAGS  qualifies bag_done: 1=caught, 0=missed
//  bag_start   out  NBAGS  per-slot 1-cycle launch pulse
//  bag_scale   out  3      arc scale for launched bag, valid with bag_start
//  active      out  NBAGS  slot in flight
//  score       out  12     caught count, saturating
//  misses      out  3      missed count, saturating at MAX_MISSES
//  game_over   out  1      round ended
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; bag_start=0, bag_scale=0, active=0, score=0,
//   misses=0, game_over=0, tick counter=0, spawn timer=0. All outputs registered.
//  Tick: counter 0..TICK_DIV-1, wraps; tick strobe 1 cycle at wrap. Runs only in RUN.
//  FSM: IDLE -start-> RUN; RUN -(misses reaches MAX_MISSES)-> OVER; OVER -start-> RUN.
//   start in RUN ignored. Entering RUN: score=0, misses=0, active=0, tick counter=0,
//   timer = GAP_MIN + (random & GAP_MASK).
//  Spawn timer: decrements on tick while >0. At 0 with >=1 free slot (active=0):
//   launch lowest-index free slot: bag_start[i]=1 for exactly 1 cycle, active[i]<=1,
//   bag_scale = random % 5 (0..4) registered the same cycle, timer reloaded as above.
//   At 0 with no free slot: timer holds 0; launch on first cycle a slot is free.
//   Max one launch per cycle.
//  Done: bag_done[i] with active[i]=1 -> active[i]<=0 next cycle; done on inactive slot
//   ignored. A slot freed in cycle N is launchable no earlier than cycle N+1 (done has
//   priority over launch on the same slot). Multiple dones same cycle: score += popcount
//   (done&active&caught), misses += popcount(done&active&~caught); both saturate.
//  OVER: entered the cycle after misses reaches MAX_MISSES; game_over=1; active forced 0;
//   no bag_start; dones ignored; score/misses held until next start.
//  Widths: score saturates at 4095; bag_scale 3 bits; random % 5 uses all 10 bits.
//  Reset mid-round: everything returns to reset values immediately; no launch pulse
//   may be emitted from the reset edge.
// TESTING (bench uses TICK_DIV=4, GAP_MIN=2, GAP_MASK=0, NBAGS=4, MAX_MISSES=3)
//  1 reset, start, random=7 -> first bag_start=4'b0001 8 clk after start tick count 2,
//    bag_scale=2, active=4'b0001; next launch slot 1 8 clk later.
//  2 fill all 4 slots, hold done low -> no bag_start, timer stays 0; pulse bag_done[2]
//    caught -> active[2]=0, score=1, bag_start=4'b0100 exactly one cycle later.
//  3 simultaneous bag_done=4'b1011, bag_caught=4'b0001 all active -> score+1, misses+2.
//  4 third miss -> game_over=1 next cycle, active=0, no further bag_start for 1000 clk;
//    start -> game_over=0, score=0, misses=0, launches resume.
//  5 bag_done on inactive slot -> score/misses unchanged; start during RUN ignored.
//  6 assert rst_n=0 mid-launch cycle -> all outputs 0 asynchronously; release -> IDLE.

Source files
------------

// File: rtl/bag_spawn_ctl.sv
// Purpose  : schedules launches of NBAGS falling-bag engines, tracks in-flight slots, score and misses.
// Latency  : all outputs registered; a launch pulse appears one clk after the timer/free-slot condition.
// Backpress: none; a launch that finds no free slot waits with the timer parked at 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               1-cycle pulse, starts a round from IDLE or OVER (ignored in RUN)
//   random[9:0]         free-running pseudo-random value (gap jitter, arc scale)
//   bag_done/bag_caught per-slot finish pulse, qualified caught(1)/missed(0)
//   bag_start           per-slot 1-cycle launch pulse; bag_scale valid alongside it
//   active              slot in flight
//   score, misses       caught count (saturating 4095), missed count (saturating MAX_MISSES)
//   game_over           round ended
module bag_spawn_ctl #(
  parameter int NBAGS      = 4,
  parameter int TICK_DIV   = 800000,
  parameter int GAP_MIN    = 32,
  parameter int GAP_MASK   = 63,
  parameter int MAX_MISSES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [9:0]       random,
  input  logic [NBAGS-1:0] bag_done,
  input  logic [NBAGS-1:0] bag_caught,
  output logic [NBAGS-1:0] bag_start,
  output logic [2:0]       bag_scale,
  output logic [NBAGS-1:0] active,
  output logic [11:0]      score,
  output logic [2:0]       misses,
  output logic             game_over
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = (GAP_MIN + GAP_MASK > 0) ? $clog2(GAP_MIN + GAP_MASK + 1) : 1;
  localparam logic [9:0]    MASK10    = 10'(GAP_MASK);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [4:0]    MISS_MAX  = 5'(MAX_MISSES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    timer_q, timer_d, timer_eff, timer_reload;
  logic [NBAGS-1:0] active_q, active_d, bag_start_q, done_v, free_oh;
  logic [2:0]       bag_scale_q, scale_d, misses_q, misses_d;
  logic [11:0]      score_q, score_d;
  logic             game_over_q;
  logic             tick, launch, go_over;
  logic [3:0]       n_hit, n_miss;
  logic [12:0]      score_sum;
  logic [4:0]       miss_sum;

  always_comb begin
    tick         = (state_q == S_RUN) && (cnt_q == TICK_LAST);
    cnt_d        = tick ? '0 : cnt_q + CW'(1);
    // Timer value after this cycle's tick: a launch fires in the same cycle the
    // timer would reach zero, so the gap is exactly reload*TICK_DIV clocks.
    timer_eff    = (tick && (timer_q != '0)) ? timer_q - TW'(1) : timer_q;
    timer_reload = TW'(GAP_MIN) + TW'(random & MASK10);

    // Dones on idle slots are dropped here, before any counting.
    done_v = bag_done & active_q;
    n_hit  = '0;
    n_miss = '0;
    for (int i = 0; i < NBAGS; i++) begin
      n_hit  = n_hit  + 4'(done_v[i] & bag_caught[i]);
      n_miss = n_miss + 4'(done_v[i] & ~bag_caught[i]);
    end

    score_sum = {1'b0, score_q} + 13'(n_hit);
    score_d   = score_sum[12] ? 12'hFFF : score_sum[11:0];
    miss_sum  = 5'(misses_q) + 5'(n_miss);
    go_over   = (miss_sum >= MISS_MAX);
    misses_d  = go_over ? MISS_MAX[2:0] : miss_sum[2:0];

    // Lowest clear bit of the registered mask: a slot freed this cycle is not
    // visible here until next cycle, so done always wins over launch.
    free_oh  = ~active_q & (active_q + NBAGS'(1));
    launch   = (state_q == S_RUN) && !go_over && (timer_eff == '0) && (free_oh != '0);
    scale_d  = 3'(random % 10'd5);
    timer_d  = launch ? timer_reload : timer_eff;
    active_d = (active_q & ~done_v) | (launch ? free_oh : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      timer_q     <= '0;
      active_q    <= '0;
      bag_start_q <= '0;
      bag_scale_q <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      game_over_q <= 1'b0;
    end else begin
      bag_start_q <= '0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            timer_q     <= timer_reload;
            active_q    <= '0;
            score_q     <= '0;
            misses_q    <= '0;
            game_over_q <= 1'b0;
          end
        end
        S_RUN: begin
          cnt_q    <= cnt_d;
          score_q  <= score_d;
          misses_q <= misses_d;
          if (go_over) begin
            // Round ends on the same edge the last miss is counted; nothing launches.
            state_q     <= S_OVER;
            game_over_q <= 1'b1;
            active_q    <= '0;
            timer_q     <= timer_eff;
          end else begin
            active_q <= active_d;
            timer_q  <= timer_d;
            if (launch) begin
              bag_start_q <= free_oh;
              bag_scale_q <= scale_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bag_start = bag_start_q;
  assign bag_scale = bag_scale_q;
  assign active    = active_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_bag_spawn_ctl.sv
// Purpose  : self-checking bench for bag_spawn_ctl with a small-parameter configuration.
// Latency  : expected launches are queued one edge ahead and matched by a negedge monitor.
// Backpress: none; stimulus is free-running and every wait is cycle-bounded.
module tb_bag_spawn_ctl;

  localparam int NB   = 4;
  localparam int TDIV = 4;
  localparam int GMIN = 2;
  localparam int GMASK = 0;
  localparam int MAXM = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] random = '0;
  logic [3:0] bag_done = '0;
  logic [3:0] bag_caught = '0;
  logic [3:0] bag_start;
  logic [2:0] bag_scale;
  logic [3:0] active;
  logic [11:0] score;
  logic [2:0] misses;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [3:0] oh;
    logic [2:0] scale;
  } launch_t;
  launch_t sb_q[$];

  // Reference model: 0 idle, 1 run, 2 over.
  int         m_state = 0;
  int         m_rc = 0;
  int         m_timer = 0;
  int         m_score = 0;
  int         m_misses = 0;
  logic [3:0] m_active = '0;

  bag_spawn_ctl #(
    .NBAGS(NB), .TICK_DIV(TDIV), .GAP_MIN(GMIN), .GAP_MASK(GMASK), .MAX_MISSES(MAXM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .random(random),
    .bag_done(bag_done), .bag_caught(bag_caught), .bag_start(bag_start),
    .bag_scale(bag_scale), .active(active), .score(score), .misses(misses),
    .game_over(game_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_rc     = 0;
    m_timer  = 0;
    m_score  = 0;
    m_misses = 0;
    m_active = '0;
  endtask

  // Predicts what the coming clock edge does with these inputs.
  task automatic model_step(input logic st, input logic [9:0] rnd,
                            input logic [3:0] dn, input logic [3:0] ct);
    logic [3:0] nxt;
    int h, m, slot;
    bit tk;
    launch_t e;
    if (m_state != 1) begin
      if (st) begin
        m_state  = 1;
        m_rc     = 0;
        m_timer  = GMIN + (int'(rnd) & GMASK);
        m_active = '0;
        m_score  = 0;
        m_misses = 0;
      end
      return;
    end
    tk = ((m_rc % TDIV) == TDIV - 1);
    m_rc++;
    if (tk && m_timer > 0) m_timer--;
    h = 0;
    m = 0;
    nxt = m_active;
    for (int i = 0; i < NB; i++) begin
      if (dn[i] && m_active[i]) begin
        nxt[i] = 1'b0;
        if (ct[i]) h++;
        else m++;
      end
    end
    m_score  = (m_score + h > 4095) ? 4095 : m_score + h;
    m_misses = (m_misses + m >= MAXM) ? MAXM : m_misses + m;
    if (m_misses == MAXM) begin
      m_state  = 2;
      m_active = '0;
      return;
    end
    if (m_timer == 0) begin
      slot = -1;
      for (int i = NB - 1; i >= 0; i--) if (!m_active[i]) slot = i;
      if (slot >= 0) begin
        e.cyc   = cyc + 1;
        e.oh    = 4'(1 << slot);
        e.scale = 3'(int'(rnd) % 5);
        sb_q.push_back(e);
        nxt[slot] = 1'b1;
        m_timer   = GMIN + (int'(rnd) & GMASK);
      end
    end
    m_active = nxt;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic drive(input logic st, input logic [9:0] rnd,
                       input logic [3:0] dn, input logic [3:0] ct);
    start      = st;
    random     = rnd;
    bag_done   = dn;
    bag_caught = ct;
    model_step(st, rnd, dn, ct);
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".active"},    32'(active),    32'(m_active));
    chk({tag, ".score"},     32'(score),     32'(m_score));
    chk({tag, ".misses"},    32'(misses),    32'(m_misses));
    chk({tag, ".game_over"}, 32'(game_over), 32'(m_state == 2));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".bag_start"}, 32'(bag_start), 32'(0));
    chk({tag, ".bag_scale"}, 32'(bag_scale), 32'(0));
    chk({tag, ".active"},    32'(active),    32'(0));
    chk({tag, ".score"},     32'(score),     32'(0));
    chk({tag, ".misses"},    32'(misses),    32'(0));
    chk({tag, ".game_over"}, 32'(game_over), 32'(0));
  endtask

  function automatic logic [3:0] rmask(input int p);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ($urandom_range(0, p - 1) == 0);
    return b;
  endfunction

  function automatic logic [9:0] rnd10();
    return 10'($urandom_range(0, 1023));
  endfunction

  // Scoreboard monitor: pops one expected launch per observed pulse.
  always @(negedge clk) begin : monitor
    launch_t e;
    if (rst_n && bag_start !== 4'b0) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_launch: bag_start=%b with none expected (cycle %0d)", bag_start, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("launch_cycle", 32'(cyc), 32'(e.cyc));
        chk("launch_slot",  32'(bag_start), 32'(e.oh));
        chk("launch_scale", 32'(bag_scale), 32'(e.scale));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit found;
    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    model_reset();
    repeat (3) drive(1'b0, 10'd7, 4'b1111, 4'b0000);
    check_state("idle");

    // First launch 8 clk after start, scale 7%5=2; next launch 8 clk later
    drive(1'b1, 10'd7, 4'b0000, 4'b0000);
    repeat (8) drive(1'b0, 10'd7, 4'b0000, 4'b0000);
    chk("t1.first_active", 32'(active), 32'(4'b0001));
    check_state("t1a");
    repeat (8) drive(1'b0, 10'd7, 4'b0000, 4'b0000);
    chk("t1.second_active", 32'(active), 32'(4'b0011));

    // Fill all slots and stall; a caught done frees slot 2 for a relaunch next cycle
    repeat (40) drive(1'b0, rnd10(), 4'b0000, 4'b0000);
    chk("t2.full", 32'(active), 32'(4'b1111));
    check_state("t2a");
    drive(1'b0, rnd10(), 4'b0100, 4'b0100);
    chk("t2.freed", 32'(active), 32'(4'b1011));
    chk("t2.score", 32'(score), 32'(1));
    drive(1'b0, rnd10(), 4'b0000, 4'b0000);
    chk("t2.refill", 32'(active), 32'(4'b1111));

    // Simultaneous dones: one caught, two missed
    drive(1'b0, rnd10(), 4'b1011, 4'b0001);
    chk("t3.score", 32'(score), 32'(2));
    chk("t3.misses", 32'(misses), 32'(2));
    check_state("t3");

    // Dones on idle slots ignored; start during RUN ignored
    drive(1'b0, rnd10(), ~m_active, 4'b0000);
    chk("t5.misses", 32'(misses), 32'(2));
    chk("t5.score", 32'(score), 32'(2));
    drive(1'b1, rnd10(), 4'b0000, 4'b0000);
    chk("t5.start_ignored", 32'(score), 32'(2));
    check_state("t5");

    // Random play until the round ends
    repeat (200) begin
      drive(1'b0, rnd10(), rmask(8), ~rmask(8));
      check_state("rand1");
    end
    for (int k = 0; k < 200 && m_state != 2; k++) begin
      drive(1'b0, rnd10(), 4'b1111, 4'b0000);
      check_state("t4.force");
    end
    chk("t4.game_over", 32'(game_over), 32'(1));
    chk("t4.active", 32'(active), 32'(0));
    chk("t4.misses", 32'(misses), 32'(MAXM));
    repeat (1000) drive(1'b0, rnd10(), rmask(3), rmask(2));
    check_state("t4.hold");
    drive(1'b1, rnd10(), 4'b0000, 4'b0000);
    chk("t4.restart_go", 32'(game_over), 32'(0));
    chk("t4.restart_score", 32'(score), 32'(0));
    chk("t4.restart_misses", 32'(misses), 32'(0));
    repeat (30) drive(1'b0, rnd10(), 4'b0000, 4'b0000);
    chk("t4.resumed", 32'(active != 4'b0), 32'(1));
    check_state("t4.resume");

    // Random play with occasional restarts
    repeat (600) begin
      drive($urandom_range(0, 63) == 0, rnd10(), rmask(6), rmask(4) != 4'b0 ? ~rmask(2) : 4'b1111);
      check_state("rand2");
    end

    // Asynchronous reset while a launch pulse is showing
    drive(1'b1, rnd10(), 4'b0000, 4'b0000);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      drive(1'b0, rnd10(), 4'b0000, 4'b0000);
      if (bag_start !== 4'b0) found = 1'b1;
    end
    chk("t6.launch_seen", 32'(found), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t6.async");
    sb_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    check_zero("t6.held");
    rst_n = 1'b1;
    repeat (20) begin
      drive(1'b0, rnd10(), rmask(2), rmask(2));
      check_state("t6.idle");
    end
    drive(1'b1, rnd10(), 4'b0000, 4'b0000);
    repeat (40) drive(1'b0, rnd10(), 4'b0000, 4'b0000);
    check_state("final");
    drive(1'b0, 10'd0, 4'b0000, 4'b0000);
    chk("sb_drain", 32'(sb_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
